muldiv_iter: RTL and testbench



---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_div_step.sv | 23 ++
 rtl/muldiv_iter.sv | 153 +++++++++++++++
 tb/tb_muldiv_iter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_RESP = 2'd3
    } muldiv_state_e;

    function automatic logic is_div(input muldiv_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division step on unsigned magnitudes: shift {rem,quo} left, trial subtract.
module muldiv_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN:0] sh;
    logic [XLEN:0] diff;

    // rem < divisor on entry, so a successful subtract always leaves diff[XLEN] clear
    always_comb begin
        sh      = {rem_in, quo_in[XLEN-1]};
        diff    = sh - {1'b0, divisor};
        quo_out = {quo_in[XLEN-2:0], ~diff[XLEN]};
        rem_out = diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0];
    end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative RV32M/RV64M multiply/divide unit with flush, fast paths and response back-pressure.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_BITS = 4,
    parameter int DIV_BITS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic            flush,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_result,
    output logic            busy
);

    localparam int NM = XLEN / MUL_BITS;
    localparam int ND = XLEN / DIV_BITS;
    localparam int CW = $clog2((NM > ND) ? NM : ND) + 1;
    localparam int XM = XLEN + MUL_BITS;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e     state, state_nx;
    muldiv_op_e        op_in, op_q;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opb, result;
    logic              sign_a, sign_b;
    logic [CW-1:0]     cnt;

    logic              accept, sa_in, sb_in, div_zero, div_ovf, fast;
    logic [XLEN-1:0]   mag_a, mag_b, fast_res;
    logic              mul_last, div_last;

    assign op_in       = muldiv_op_e'(req_op);
    assign req_ready   = (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign resp_valid  = (state == S_RESP);
    assign resp_result = result;
    assign accept      = req_valid & req_ready & ~flush;
    assign mul_last    = (cnt == CW'(NM - 1));
    assign div_last    = (cnt == CW'(ND - 1));

    always_comb begin
        sa_in    = req_a[XLEN-1] & (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
        sb_in    = req_b[XLEN-1] & (op_in inside {OP_MULH, OP_DIV, OP_REM});
        mag_a    = sa_in ? -req_a : req_a;
        mag_b    = sb_in ? -req_b : req_b;
        div_zero = is_div(op_in) && (req_b == '0);
        div_ovf  = (op_in inside {OP_DIV, OP_REM}) && (req_a == MIN_NEG) && (&req_b);
        fast     = div_zero | div_ovf;
        if (div_zero)
            fast_res = (op_in inside {OP_DIV, OP_DIVU}) ? '1 : req_a;
        else
            fast_res = (op_in == OP_DIV) ? MIN_NEG : '0;
    end

    // Multiply: acc holds {partial high, remaining multiplier}; retire MUL_BITS per cycle
    logic [XM-1:0]     pp, upper;
    logic [2*XLEN-1:0] mul_nx, prod;

    always_comb begin
        pp     = XM'(opb) * XM'(acc[MUL_BITS-1:0]);
        upper  = XM'(acc[2*XLEN-1:XLEN]) + pp;
        mul_nx = {upper, acc[XLEN-1:MUL_BITS]};
        prod   = (sign_a ^ sign_b) ? -mul_nx : mul_nx;
    end

    // Divide: acc holds {rem, quo}, opb holds |divisor|
    logic [XLEN-1:0] rem_c [DIV_BITS+1];
    logic [XLEN-1:0] quo_c [DIV_BITS+1];

    assign rem_c[0] = acc[2*XLEN-1:XLEN];
    assign quo_c[0] = acc[XLEN-1:0];

    for (genvar i = 0; i < DIV_BITS; i++) begin : g_div
        muldiv_div_step #(.XLEN(XLEN)) u_step (
            .rem_in  (rem_c[i]),
            .quo_in  (quo_c[i]),
            .divisor (opb),
            .rem_out (rem_c[i+1]),
            .quo_out (quo_c[i+1])
        );
    end

    logic [XLEN-1:0] quo_fix, rem_fix, div_res, mul_res;

    always_comb begin
        quo_fix = (op_q == OP_DIV && (sign_a ^ sign_b)) ? -quo_c[DIV_BITS] : quo_c[DIV_BITS];
        rem_fix = (op_q == OP_REM && sign_a) ? -rem_c[DIV_BITS] : rem_c[DIV_BITS];
        div_res = (op_q inside {OP_DIV, OP_DIVU}) ? quo_fix : rem_fix;
        mul_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept) state_nx = fast ? S_RESP : (is_div(op_in) ? S_DIV : S_MUL);
            S_MUL:  if (mul_last) state_nx = S_RESP;
            S_DIV:  if (div_last) state_nx = S_RESP;
            S_RESP: if (resp_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (flush) state_nx = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q   <= OP_MUL;
            acc    <= '0;
            opb    <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            cnt    <= '0;
            result <= '0;
        end else if (accept) begin
            op_q   <= op_in;
            sign_a <= sa_in;
            sign_b <= sb_in;
            cnt    <= '0;
            if (is_div(op_in)) begin
                acc <= {{XLEN{1'b0}}, mag_a};
                opb <= mag_b;
            end else begin
                acc <= {{XLEN{1'b0}}, mag_b};
                opb <= mag_a;
            end
            if (fast) result <= fast_res;
        end else if (!flush) begin
            if (state == S_MUL) begin
                acc <= mul_nx;
                cnt <= cnt + 1'b1;
                if (mul_last) result <= mul_res;
            end
            if (state == S_DIV) begin
                acc <= {rem_c[DIV_BITS], quo_c[DIV_BITS]};
                cnt <= cnt + 1'b1;
                if (div_last) result <= div_res;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter: three configurations share stimulus, one is selected at a time.
module tb_muldiv_iter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rv, rr, fl;
    logic [2:0]  op;
    logic [63:0] a, b;
    int          sel;
    int          n_cmp, n_bad;

    logic        rdy0, vld0, bsy0, rdy1, vld1, bsy1, rdy2, vld2, bsy2;
    logic [31:0] res0, res1;
    logic [63:0] res2;
    logic        cur_rdy, cur_vld, cur_busy;
    logic [63:0] cur_res;

    muldiv_iter #(.XLEN(32), .MUL_BITS(4), .DIV_BITS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv & (sel == 0)), .req_ready(rdy0),
        .req_op(op), .req_a(a[31:0]), .req_b(b[31:0]), .flush(fl),
        .resp_valid(vld0), .resp_ready(rr), .resp_result(res0), .busy(bsy0));

    muldiv_iter #(.XLEN(32), .MUL_BITS(4), .DIV_BITS(4)) u1 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv & (sel == 1)), .req_ready(rdy1),
        .req_op(op), .req_a(a[31:0]), .req_b(b[31:0]), .flush(fl),
        .resp_valid(vld1), .resp_ready(rr), .resp_result(res1), .busy(bsy1));

    muldiv_iter #(.XLEN(64), .MUL_BITS(4), .DIV_BITS(1)) u2 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv & (sel == 2)), .req_ready(rdy2),
        .req_op(op), .req_a(a), .req_b(b), .flush(fl),
        .resp_valid(vld2), .resp_ready(rr), .resp_result(res2), .busy(bsy2));

    always_comb begin
        case (sel)
            1:       begin cur_rdy = rdy1; cur_vld = vld1; cur_busy = bsy1; cur_res = {32'b0, res1}; end
            2:       begin cur_rdy = rdy2; cur_vld = vld2; cur_busy = bsy2; cur_res = res2; end
            default: begin cur_rdy = rdy0; cur_vld = vld0; cur_busy = bsy0; cur_res = {32'b0, res0}; end
        endcase
    end

    // lat = number of edges after the accept edge until resp_valid is seen (0 = fast path)
    task automatic issue(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y,
                         output int lat, output logic [63:0] res);
        op = o; a = x; b = y; rv = 1'b1;
        @(posedge clk); #1;
        rv = 1'b0; lat = 0;
        while (!cur_vld && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = cur_res;
    endtask

    task automatic finish_resp;
        rr = 1'b1;
        @(posedge clk); #1;
        rr = 1'b0;
    endtask

    task automatic test_reset;
        sel = 0; rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (cur_rdy !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b exp 1", cur_rdy); end
        n_cmp++; if (cur_vld !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b exp 0", cur_vld); end
        n_cmp++; if (cur_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", cur_busy); end
        n_cmp++; if (cur_res !== 64'h0) begin n_bad++; $display("FAIL reset_result got %h exp 0", cur_res); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mul;
        int lat; logic [63:0] r;
        sel = 0;
        issue(3'd1, 64'hFFFFFFFF, 64'hFFFFFFFF, lat, r); finish_resp();
        n_cmp++; if (r !== 64'h0) begin n_bad++; $display("FAIL mulh got %h exp 0", r); end
        n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL mulh_latency got %0d exp 8", lat); end
        issue(3'd0, 64'hFFFFFFFF, 64'hFFFFFFFF, lat, r); finish_resp();
        n_cmp++; if (r !== 64'h1) begin n_bad++; $display("FAIL mul got %h exp 1", r); end
        issue(3'd2, 64'h80000000, 64'hFFFFFFFF, lat, r); finish_resp();
        n_cmp++; if (r !== 64'h80000000) begin n_bad++; $display("FAIL mulhsu got %h exp 80000000", r); end
        issue(3'd3, 64'h80000000, 64'hFFFFFFFF, lat, r); finish_resp();
        n_cmp++; if (r !== 64'h7FFFFFFF) begin n_bad++; $display("FAIL mulhu got %h exp 7fffffff", r); end
        sel = 2;
        issue(3'd3, '1, '1, lat, r); finish_resp();
        n_cmp++; if (r !== 64'hFFFFFFFFFFFFFFFE) begin n_bad++; $display("FAIL mulhu64 got %h exp fffffffffffffffe", r); end
        n_cmp++; if (lat !== 16) begin n_bad++; $display("FAIL mulhu64_latency got %0d exp 16", lat); end
    endtask

    task automatic test_div;
        int lat; logic [63:0] r;
        sel = 0;
        issue(3'd4, 64'hFFFFFFF9, 64'h2, lat, r); finish_resp();
        n_cmp++; if (r !== 64'hFFFFFFFD) begin n_bad++; $display("FAIL div got %h exp fffffffd", r); end
        n_cmp++; if (lat !== 32) begin n_bad++; $display("FAIL div_latency got %0d exp 32", lat); end
        issue(3'd6, 64'hFFFFFFF9, 64'h2, lat, r); finish_resp();
        n_cmp++; if (r !== 64'hFFFFFFFF) begin n_bad++; $display("FAIL rem got %h exp ffffffff", r); end
        sel = 1;
        issue(3'd4, 64'hFFFFFFF9, 64'h2, lat, r); finish_resp();
        n_cmp++; if (r !== 64'hFFFFFFFD) begin n_bad++; $display("FAIL div4 got %h exp fffffffd", r); end
        n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL div4_latency got %0d exp 8", lat); end
        issue(3'd6, 64'hFFFFFFF9, 64'h2, lat, r); finish_resp();
        n_cmp++; if (r !== 64'hFFFFFFFF) begin n_bad++; $display("FAIL rem4 got %h exp ffffffff", r); end
        sel = 2;
        issue(3'd4, 64'hFFFFFFFFFFFFFFF9, 64'h2, lat, r); finish_resp();
        n_cmp++; if (r !== 64'hFFFFFFFFFFFFFFFD) begin n_bad++; $display("FAIL div64 got %h exp fffffffffffffffd", r); end
        n_cmp++; if (lat !== 64) begin n_bad++; $display("FAIL div64_latency got %0d exp 64", lat); end
        issue(3'd6, 64'hFFFFFFFFFFFFFFF9, 64'h2, lat, r); finish_resp();
        n_cmp++; if (r !== 64'hFFFFFFFFFFFFFFFF) begin n_bad++; $display("FAIL rem64 got %h exp ffffffffffffffff", r); end
    endtask

    task automatic test_fast_path;
        int lat; logic [63:0] r;
        sel = 0;
        issue(3'd5, 64'h5, 64'h0, lat, r); finish_resp();
        n_cmp++; if (r !== 64'hFFFFFFFF) begin n_bad++; $display("FAIL divu_by0 got %h exp ffffffff", r); end
        n_cmp++; if (lat !== 0) begin n_bad++; $display("FAIL divu_by0_latency got %0d exp 0", lat); end
        issue(3'd7, 64'h5, 64'h0, lat, r); finish_resp();
        n_cmp++; if (r !== 64'h5) begin n_bad++; $display("FAIL remu_by0 got %h exp 5", r); end
        issue(3'd4, 64'h80000000, 64'hFFFFFFFF, lat, r); finish_resp();
        n_cmp++; if (r !== 64'h80000000) begin n_bad++; $display("FAIL div_ovf got %h exp 80000000", r); end
        n_cmp++; if (lat !== 0) begin n_bad++; $display("FAIL div_ovf_latency got %0d exp 0", lat); end
        issue(3'd6, 64'h80000000, 64'hFFFFFFFF, lat, r); finish_resp();
        n_cmp++; if (r !== 64'h0) begin n_bad++; $display("FAIL rem_ovf got %h exp 0", r); end
        sel = 2;
        issue(3'd4, 64'h8000000000000000, '1, lat, r); finish_resp();
        n_cmp++; if (r !== 64'h8000000000000000) begin n_bad++; $display("FAIL div64_ovf got %h exp 8000000000000000", r); end
    endtask

    task automatic test_back_to_back;
        int lat; logic [63:0] r;
        sel = 0;
        issue(3'd0, 64'h3, 64'h5, lat, r);
        n_cmp++; if (r !== 64'hF) begin n_bad++; $display("FAIL bp_mul got %h exp f", r); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (cur_vld !== 1'b1) begin n_bad++; $display("FAIL bp_valid cyc %0d got %b exp 1", i, cur_vld); end
            n_cmp++; if (cur_res !== 64'hF) begin n_bad++; $display("FAIL bp_result cyc %0d got %h exp f", i, cur_res); end
            n_cmp++; if (cur_rdy !== 1'b0) begin n_bad++; $display("FAIL bp_ready cyc %0d got %b exp 0", i, cur_rdy); end
        end
        finish_resp();
        n_cmp++; if (cur_rdy !== 1'b1) begin n_bad++; $display("FAIL bp_ready_after got %b exp 1", cur_rdy); end
        issue(3'd3, 64'h80000000, 64'hFFFFFFFF, lat, r); finish_resp();
        n_cmp++; if (r !== 64'h7FFFFFFF) begin n_bad++; $display("FAIL b2b_mulhu got %h exp 7fffffff", r); end
    endtask

    task automatic test_flush;
        int lat; logic [63:0] r; bit seen;
        sel = 0;
        op = 3'd5; a = 64'd100; b = 64'd3; rv = 1'b1;
        @(posedge clk); #1;
        rv = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        fl = 1'b1;
        @(posedge clk); #1;
        fl = 1'b0;
        n_cmp++; if (cur_busy !== 1'b0) begin n_bad++; $display("FAIL flush_busy got %b exp 0", cur_busy); end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (cur_vld) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL flush_no_resp got %b exp 0", seen); end
        issue(3'd0, 64'd7, 64'd6, lat, r); finish_resp();
        n_cmp++; if (r !== 64'd42) begin n_bad++; $display("FAIL flush_then_mul got %h exp 2a", r); end
        n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL flush_then_mul_latency got %0d exp 8", lat); end
    endtask

    task automatic test_reset_mid;
        int lat; logic [63:0] r;
        sel = 0;
        op = 3'd4; a = 64'd1000; b = 64'd7; rv = 1'b1;
        @(posedge clk); #1;
        rv = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        n_cmp++; if (cur_busy !== 1'b1) begin n_bad++; $display("FAIL midrst_busy_before got %b exp 1", cur_busy); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (cur_vld !== 1'b0) begin n_bad++; $display("FAIL midrst_valid got %b exp 0", cur_vld); end
        n_cmp++; if (cur_busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got %b exp 0", cur_busy); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (cur_rdy !== 1'b1) begin n_bad++; $display("FAIL midrst_ready got %b exp 1", cur_rdy); end
        issue(3'd5, 64'd1000, 64'd7, lat, r); finish_resp();
        n_cmp++; if (r !== 64'd142) begin n_bad++; $display("FAIL midrst_divu got %h exp 8e", r); end
        issue(3'd7, 64'd1000, 64'd7, lat, r); finish_resp();
        n_cmp++; if (r !== 64'd6) begin n_bad++; $display("FAIL midrst_remu got %h exp 6", r); end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rv = 1'b0; rr = 1'b0; fl = 1'b0; op = 3'd0; a = '0; b = '0; sel = 0; rst_n = 1'b0;
        test_reset();
        test_mul();
        test_div();
        test_fast_path();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
